// File: rtl/nbcac_decoder_20_pkg.sv
// Shared constants for the 20-bit NBCAC decoder: Fibonacci bit weights,
// datapath widths and the top of the legal data range.
package nbcac_pkg;

  localparam int DATA_W = 14;
  localparam int CODE_W = 20;

  // Largest value that fits in the decoded data word.
  localparam int NBCAC_DATA_MAX = 16383;

  // Weight of codeword bit k (k = 1..20): w[k] = F(k+1), with F(1) = F(2) = 1.
  localparam int unsigned NBCAC_W20 [1:20] = '{
    1, 2, 3, 5, 8, 13, 21, 34, 55, 89,
    144, 233, 377, 610, 987, 1597, 2584, 4181, 6765, 10946
  };

endpackage

// File: rtl/nbcac_decoder_20_core.sv
// Combinational half-sum unit. It adds up the weights of the set bits in a
// 10-bit slice of the codeword. BASE is the codeword index of slice[0].
module nbcac_14di_decoder_core
  import nbcac_pkg::*;
#(
  parameter int BASE  = 1,
  parameter int SUM_W = 15
) (
  input  logic [9:0]       slice,
  output logic [SUM_W-1:0] sum
);

  // Weighted sum of the slice. The weights are constants, so each term is a
  // gated constant and the loop reduces to a small adder tree.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (slice[i]) sum = sum + SUM_W'(NBCAC_W20[BASE + i]);
    end
  end

endmodule

// File: rtl/nbcac_decoder_20.sv
// NBCAC 20-bit -> 14-bit receive decoder. It is a two-stage valid/ready
// pipeline:
//   stage 1 registers the low and high half sums,
//   stage 2 registers the final sum, data_out and a range-error flag.
// Optional build macro NBCAC_DEC_ERRCNT_EN adds a saturating error counter
// (err_count) and its synchronous clear (err_clr).
module nbcac_decoder_20
  import nbcac_pkg::*;
`ifdef NBCAC_DEC_ERRCNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              code_err,
  output logic              out_valid,
  input  logic              out_ready
`ifdef NBCAC_DEC_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_clr
`endif
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_en, s2_en;
  logic [7:0]      lo_sum, s1_lo;
  logic [14:0]     hi_sum, s1_hi;
  logic [14:0]     s2_sum;

  // A stage advances when it is empty or when the stage after it drains.
  // in_ready therefore follows out_ready combinationally.
  assign s2_en     = ~vld_pipe[2] | out_ready;
  assign s1_en     = ~vld_pipe[1] | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = vld_pipe[2];

  // Half sums: bits 1..10 peak at 231 and fit in 8 bits; bits 11..20 need 15.
  nbcac_14di_decoder_core #(.BASE(1),  .SUM_W(8))  u_lo (
    .slice (code_in[9:0]),
    .sum   (lo_sum)
  );

  nbcac_14di_decoder_core #(.BASE(11), .SUM_W(15)) u_hi (
    .slice (code_in[19:10]),
    .sum   (hi_sum)
  );

  // The full sum is at most 28655, so a 15-bit add never overflows.
  assign s2_sum = s1_hi + 15'(s1_lo);

  // Stage 1: capture the half sums. An idle input cycle leaves a bubble here.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_lo       <= '0;
      s1_hi       <= '0;
    end else if (s1_en) begin
      vld_pipe[1] <= in_valid;
      s1_lo       <= lo_sum;
      s1_hi       <= hi_sum;
    end
  end

  // Stage 2: the output registers. They hold steady while the consumer stalls.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      data_out    <= '0;
      code_err    <= 1'b0;
    end else if (s2_en) begin
      vld_pipe[2] <= vld_pipe[1];
      data_out    <= s2_sum[DATA_W-1:0];
      code_err    <= (s2_sum > 15'(NBCAC_DATA_MAX));
    end
  end

`ifdef NBCAC_DEC_ERRCNT_EN
  // Count flagged words when they leave the decoder. The count saturates
  // rather than wrapping, and a clear wins over an increment in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (vld_pipe[2] && out_ready && code_err && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nbcac_decoder_20.sv
// Directed and streaming bench for nbcac_decoder_20. Inputs are driven on the
// falling edge and outputs are sampled 1 ns later, well clear of the rising edge.
module tb_nbcac_decoder_20;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [19:0] code_in;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] data_out;
  logic        code_err;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

`ifdef NBCAC_DEC_ERRCNT_EN
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic        err_clr;
  logic        in_ready2, code_err2, out_valid2;
  logic [13:0] data_out2;

  nbcac_decoder_20 #(.CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .code_err(code_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count), .err_clr(err_clr)
  );

  // Second copy with a 2-bit counter, used to exercise saturation.
  nbcac_decoder_20 #(.CNT_W(2)) dut2 (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready2), .data_out(data_out2), .code_err(code_err2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .err_count(err_count2), .err_clr(err_clr)
  );
`else
  nbcac_decoder_20 dut (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .code_err(code_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );
`endif

  // Reference decode. The weights are built with the Fibonacci recurrence,
  // starting w1 = 1 and w2 = 2.
  function automatic int ref_sum(input logic [19:0] c);
    int a, b, t, s;
    a = 1; b = 2; s = 0;
    for (int k = 0; k < 20; k++) begin
      if (c[k]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b0;
`ifdef NBCAC_DEC_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0 || data_out !== 14'd0 || code_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%0d e=%b, want 0/0/0",
               out_valid, data_out, code_err);
    end
`ifdef NBCAC_DEC_ERRCNT_EN
    total++;
    if (err_count !== 16'd0) begin
      bad++; $display("FAIL reset_errcnt: got %0d, want 0", err_count);
    end
`endif
    @(negedge clock) rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  // Single words with hand-computed results. Each one is checked for the
  // two-cycle latency.
  task automatic test_vectors();
    logic [19:0] codes [10];
    int          exp_d [10];
    logic        exp_e [10];
    codes = '{20'h00000, 20'h00001, 20'h00002, 20'h80000, 20'hA0000,
              20'hC0000, 20'hFFFFF, 20'h003FF, 20'hA4882, 20'hA4883};
    exp_d = '{0, 1, 2, 10946, 15127, 1327, 12271, 231, 16383, 0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = 1'b1; code_in = codes[i]; out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL vec%0d_early: out_valid=%b, want 0", i, out_valid);
      end
      @(negedge clock);
      #1;
      total++;
      if (out_valid !== 1'b1 || data_out !== 14'(exp_d[i]) || code_err !== exp_e[i]) begin
        bad++;
        $display("FAIL vec%0d: got v=%b d=%0d e=%b, want 1/%0d/%b",
                 i, out_valid, data_out, code_err, exp_d[i], exp_e[i]);
      end
    end
    @(negedge clock);
  endtask

  // 1000 random words against random backpressure. The scoreboard checks
  // order, loss and duplication, and that outputs hold while stalled.
  task automatic test_stream();
    int          q[$];
    int          sent = 0, cyc = 0, cnt, exp;
    logic        stall_prev = 1'b0;
    logic [13:0] d_prev = '0;
    logic        e_prev = 1'b0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      code_in   = 20'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      cnt = q.size();
      total++;
      if (in_ready !== !(cnt == 2 && !out_ready)) begin
        bad++;
        $display("FAIL stream_in_ready: got %b with %0d in flight, out_ready=%b",
                 in_ready, cnt, out_ready);
      end
      if (stall_prev) begin
        total++;
        if (out_valid !== 1'b1 || data_out !== d_prev || code_err !== e_prev) begin
          bad++;
          $display("FAIL stream_stall_hold: got v=%b d=%0d e=%b, want 1/%0d/%b",
                   out_valid, data_out, code_err, d_prev, e_prev);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (cnt == 0) begin
          bad++; $display("FAIL stream_extra: output %0d with nothing in flight", data_out);
        end else begin
          exp = q.pop_front();
          if (data_out !== exp[13:0] || code_err !== (exp > 16383)) begin
            bad++;
            $display("FAIL stream_data: got d=%0d e=%b, want %0d/%b",
                     data_out, code_err, exp[13:0], (exp > 16383));
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sum(code_in));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      d_prev = data_out; e_prev = code_err;
    end
    total++;
    if (sent != 1000 || q.size() != 0) begin
      bad++; $display("FAIL stream_timeout: sent=%0d pending=%0d", sent, q.size());
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
  endtask

  // With the input and output both always ready, the decoder must pass one
  // word per cycle after the two-cycle fill.
  task automatic test_back_to_back();
    logic [19:0] codes [50];
    for (int c = 0; c < 52; c++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = (c < 50);
      if (c < 50) begin
        codes[c] = 20'(c * 20641 + 7);
        code_in  = codes[c];
      end
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== (c >= 2)) begin
        bad++;
        $display("FAIL b2b_flow c=%0d: in_ready=%b out_valid=%b, want 1/%b",
                 c, in_ready, out_valid, (c >= 2));
      end
      if (c >= 2) begin
        total++;
        if (data_out !== 14'(ref_sum(codes[c-2])) ||
            code_err !== (ref_sum(codes[c-2]) > 16383)) begin
          bad++;
          $display("FAIL b2b_data c=%0d: got %0d/%b, want %0d", c, data_out,
                   code_err, ref_sum(codes[c-2]));
        end
      end
    end
    @(negedge clock) in_valid = 1'b0;
    @(negedge clock);
  endtask

  // Fill both stages, reset asynchronously, then check that nothing from
  // before the reset comes out afterwards.
  task automatic test_reset_midstream();
    int  waited = 0;
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; code_in = 20'h00001;
    @(negedge clock) code_in = 20'h00002;
    @(negedge clock) in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_fill: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || data_out !== 14'd0) begin
      bad++;
      $display("FAIL rst_async: out_valid=%b d=%0d, want 0/0", out_valid, data_out);
    end
    @(negedge clock) rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; code_in = 20'h00400;
    @(negedge clock) in_valid = 1'b0;
    #1;
    while (!out_valid && waited < 10) begin
      @(negedge clock); #1; waited++;
    end
    total++;
    if (!out_valid || data_out !== 14'd144) begin
      bad++;
      $display("FAIL rst_first_out: v=%b d=%0d, want 1/144", out_valid, data_out);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

`ifdef NBCAC_DEC_ERRCNT_EN
  task automatic send_errors(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b1; code_in = 20'hFFFFF; out_ready = 1'b1;
    end
    @(negedge clock) in_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_errcnt();
    @(negedge clock) err_clr = 1'b1;
    @(negedge clock) err_clr = 1'b0;
    send_errors(3);
    #1;
    total++;
    if (err_count !== 16'd3 || err_count2 !== 2'd3) begin
      bad++; $display("FAIL errcnt3: got %0d/%0d, want 3/3", err_count, err_count2);
    end
    send_errors(2);
    #1;
    total++;
    if (err_count !== 16'd5 || err_count2 !== 2'd3) begin
      bad++; $display("FAIL errcnt_sat: got %0d/%0d, want 5/3", err_count, err_count2);
    end
    @(negedge clock);
    in_valid = 1'b1; code_in = 20'hFFFFF;
    @(negedge clock) in_valid = 1'b0;
    @(negedge clock) err_clr = 1'b1;
    #1;
    total++;
    if (!(out_valid && code_err)) begin
      bad++; $display("FAIL errclr_setup: v=%b e=%b, want 1/1", out_valid, code_err);
    end
    @(negedge clock) err_clr = 1'b0;
    #1;
    total++;
    if (err_count !== 16'd0 || err_count2 !== 2'd0) begin
      bad++; $display("FAIL errclr: got %0d/%0d, want 0/0", err_count, err_count2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_stream();
    test_back_to_back();
    test_reset_midstream();
`ifdef NBCAC_DEC_ERRCNT_EN
    test_errcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
